// File: rtl/io_input_ctrl.sv
// Memory-mapped input controller: samples four raw input ports on a programmable tick,
// commits a value only after two consecutive matching samples, and flags changes via irq.
module io_input_ctrl #(
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned RST_PERIOD = 255
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    input  logic [31:0] in_port3,
    output logic [31:0] io_read_data,
    output logic        irq
);

    typedef enum logic [0:0] {StStop, StRun} state_e;

    state_e              state_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] period_q;
    logic [3:0]          mask_q;
    logic [3:0]          chg_q;
    logic [31:0]         val_q  [4];
    logic [31:0]         cand_q [4];
    logic                irq_q;

    logic [31:0] in_w [4];
    logic [5:0]  sel;
    logic        wr_status, wr_ctrl, wr_period, wr_mask;
    logic        tick;
    logic [3:0]  commit;
    logic [3:0]  chg_d;

    assign in_w[0] = in_port0;
    assign in_w[1] = in_port1;
    assign in_w[2] = in_port2;
    assign in_w[3] = in_port3;

    assign sel       = addr[7:2];
    assign wr_status = wr_en && (sel == 6'd4);
    assign wr_ctrl   = wr_en && (sel == 6'd5);
    assign wr_period = wr_en && (sel == 6'd6);
    assign wr_mask   = wr_en && (sel == 6'd7);
    assign tick      = (state_q == StRun) && (cnt_q == period_q);

    // Only the decoded address bits and the period-wide slice of write data matter.
    logic unused_bits;
    assign unused_bits = ^{addr[31:8], addr[1:0], wr_data[31:PERIOD_W]};

    always_comb begin
        commit = '0;
        chg_d  = chg_q;
        for (int i = 0; i < 4; i++) begin
            commit[i] = tick && (in_w[i] == cand_q[i]) && (in_w[i] != val_q[i]);
            if ((rd_en && (sel == 6'(i))) || (wr_status && wr_data[i])) begin
                chg_d[i] = 1'b0;
            end
            // A commit on the same edge as a clear must win.
            if (commit[i]) begin
                chg_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            state_q  <= StStop;
            cnt_q    <= '0;
            period_q <= PERIOD_W'(RST_PERIOD);
            mask_q   <= '0;
            chg_q    <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                val_q[i]  <= '0;
                cand_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                state_q <= wr_data[0] ? StRun : StStop;
            end
            unique case (state_q)
                StStop: cnt_q <= '0;
                StRun:  cnt_q <= (wr_period || tick) ? '0 : cnt_q + 1'b1;
                default: cnt_q <= '0;
            endcase
            if (wr_period) begin
                period_q <= wr_data[PERIOD_W-1:0];
            end
            if (wr_mask) begin
                mask_q <= wr_data[3:0];
            end
            for (int i = 0; i < 4; i++) begin
                if (tick) begin
                    cand_q[i] <= in_w[i];
                end
                if (commit[i]) begin
                    val_q[i] <= in_w[i];
                end
            end
            chg_q <= chg_d;
            irq_q <= |(chg_q & mask_q);
        end
    end

    assign irq = irq_q;

    always_comb begin
        io_read_data = '0;
        case (sel)
            6'd0:    io_read_data = val_q[0];
            6'd1:    io_read_data = val_q[1];
            6'd2:    io_read_data = val_q[2];
            6'd3:    io_read_data = val_q[3];
            6'd4:    io_read_data = {28'b0, chg_q};
            6'd5:    io_read_data = {31'b0, state_q == StRun};
            6'd6:    io_read_data = 32'(period_q);
            6'd7:    io_read_data = {28'b0, mask_q};
            default: io_read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the register map and debounce rules.
module tb_io_input_ctrl;

    localparam logic [31:0] A_STATUS = 32'h10;
    localparam logic [31:0] A_CTRL   = 32'h14;
    localparam logic [31:0] A_PERIOD = 32'h18;
    localparam logic [31:0] A_MASK   = 32'h1C;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] in_p [4];
    logic [31:0] io_read_data;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: tick when the run-cycle count since restart hits period mod (period+1).
    logic        m_en;
    logic [15:0] m_period;
    longint      m_phase;
    logic [3:0]  m_mask;
    logic [3:0]  m_chg;
    logic [31:0] m_val  [4];
    logic [31:0] m_cand [4];
    logic        m_irq;

    always #10 io_clk = ~io_clk;

    io_input_ctrl dut (
        .io_clk       (io_clk),
        .reset        (reset),
        .addr         (addr),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .in_port0     (in_p[0]),
        .in_port1     (in_p[1]),
        .in_port2     (in_p[2]),
        .in_port3     (in_p[3]),
        .io_read_data (io_read_data),
        .irq          (irq)
    );

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [5:0] s;
        s = a[7:2];
        if (s < 6'd4) return m_val[s[1:0]];
        if (s == 6'd4) return {28'b0, m_chg};
        if (s == 6'd5) return {31'b0, m_en};
        if (s == 6'd6) return {16'b0, m_period};
        if (s == 6'd7) return {28'b0, m_mask};
        return 32'h0;
    endfunction

    task automatic model_edge();
        logic [5:0]  s;
        logic        tk;
        logic [3:0]  n_chg;
        s = addr[7:2];
        if (reset) begin
            m_en = 0; m_period = 16'd255; m_phase = 0; m_mask = 0; m_chg = 0; m_irq = 0;
            for (int i = 0; i < 4; i++) begin
                m_val[i] = 0;
                m_cand[i] = 0;
            end
            return;
        end
        tk = m_en && ((m_phase % (longint'(m_period) + 1)) == longint'(m_period));
        m_irq = |(m_chg & m_mask);
        n_chg = m_chg;
        for (int i = 0; i < 4; i++) begin
            if (rd_en && s == 6'(i)) n_chg[i] = 1'b0;
            if (wr_en && s == 6'd4 && wr_data[i]) n_chg[i] = 1'b0;
            if (tk) begin
                if (in_p[i] == m_cand[i] && in_p[i] != m_val[i]) begin
                    m_val[i] = in_p[i];
                    n_chg[i] = 1'b1;
                end
                m_cand[i] = in_p[i];
            end
        end
        m_chg = n_chg;
        if (!m_en || (wr_en && s == 6'd6)) m_phase = 0;
        else m_phase = m_phase + 1;
        if (wr_en && s == 6'd5) m_en = wr_data[0];
        if (wr_en && s == 6'd6) m_period = wr_data[15:0];
        if (wr_en && s == 6'd7) m_mask = wr_data[3:0];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge io_clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 0;
        wr_en = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wr_data = d; wr_en = 1; rd_en = 0;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; rd_en = 1; wr_en = 0;
        cyc();
        idle();
    endtask

    // Side-effect-free peek at a register (rd_en low).
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        idle();
        addr = a;
        #1;
        d = io_read_data;
    endtask

    task automatic sweep(input string tag);
        idle();
        for (int i = 0; i < 8; i++) begin
            addr = 32'(i * 4);
            #1;
            check($sformatf("%s_reg%0d", tag, i), io_read_data, model_read(addr));
        end
        check({tag, "_irq"}, 32'(irq), 32'(m_irq));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] r;
        logic [5:0]  s;

        reset = 1; addr = 0; rd_en = 0; wr_en = 0; wr_data = 0;
        for (int i = 0; i < 4; i++) in_p[i] = 0;
        cyc();
        reset = 0;
        sweep("reset");
        peek(A_PERIOD, d);
        check("reset_period", d, 32'd255);

        // Committed value after two matching ticks, irq one cycle after chg.
        in_p[2] = 32'hA5A5_0001;
        wr(A_PERIOD, 32'd3);
        wr(A_MASK, 32'h4);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 7) begin
                peek(A_STATUS, d);
                check("p29_chg_before", d, 32'h0);
            end
            if (k == 8) begin
                peek(32'h8, d);
                check("p29_val2", d, 32'hA5A5_0001);
                peek(A_STATUS, d);
                check("p29_chg", d, 32'h4);
                check("p29_irq_lag", 32'(irq), 32'h0);
            end
            if (k == 9) check("p29_irq", 32'(irq), 32'h1);
        end
        sweep("p29");

        // One-cycle glitch at period 0 must never commit.
        wr(A_STATUS, 32'hF);
        wr(A_MASK, 32'h1);
        wr(A_PERIOD, 32'h0);
        in_p[0] = 32'h1;
        cyc();
        in_p[0] = 32'h0;
        for (int k = 0; k < 4; k++) cyc();
        peek(32'h0, d);
        check("p30_val0", d, 32'h0);
        peek(A_STATUS, d);
        check("p30_chg0", 32'(d[0]), 32'h0);
        check("p30_irq", 32'(irq), 32'h0);
        sweep("p30");

        // STATUS W1C and read-clear.
        in_p[0] = 32'h11; in_p[1] = 32'h22; in_p[2] = 32'h33; in_p[3] = 32'h44;
        for (int k = 0; k < 3; k++) cyc();
        peek(A_STATUS, d);
        check("p31_all", d, 32'hF);
        wr(A_STATUS, 32'h5);
        peek(A_STATUS, d);
        check("p31_w1c", d, 32'hA);
        rd(32'h4);
        peek(A_STATUS, d);
        check("p31_rdclr", d, 32'h8);

        // Set beats clear on the same edge.
        wr(A_STATUS, 32'hF);
        in_p[3] = 32'h55;
        cyc();
        wr(A_STATUS, 32'h8);
        peek(A_STATUS, d);
        check("p32_setwins", d, 32'h8);
        peek(32'hC, d);
        check("p32_val3", d, 32'h55);

        // Stop mid-count freezes state; restart counts from zero.
        wr(A_PERIOD, 32'd3);
        cyc();
        cyc();
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 4; i++) in_p[i] = 32'h99;
        for (int k = 0; k < 10; k++) cyc();
        peek(32'h0, d);
        check("p33_hold_val0", d, 32'h11);
        peek(A_STATUS, d);
        check("p33_hold_chg", d, 32'h8);
        wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 7) begin
                peek(32'h0, d);
                check("p33_not_yet", d, 32'h11);
            end
        end
        peek(32'h0, d);
        check("p33_resume", d, 32'h99);
        sweep("p33");

        // Unmapped read, ignored write to a value register.
        peek(32'h20, d);
        check("p34_unmapped", d, 32'h0);
        wr(32'h0, 32'hFFFF_FFFF);
        peek(32'h0, d);
        check("p34_val0_ro", d, 32'h99);

        // Reset mid-debounce discards the candidate.
        wr(A_PERIOD, 32'h0);
        in_p[1] = 32'h7;
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        wr(A_CTRL, 32'h1);
        cyc();
        peek(32'h4, d);
        check("p28_fresh", d, 32'h0);
        sweep("p28");

        // Randomized traffic.
        wr(A_CTRL, 32'h1);
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            s = 6'($urandom_range(0, 11));
            r = $urandom;
            addr = {r[31:8], s, r[1:0]};
            rd_en = ($urandom_range(0, 3) == 0);
            wr_en = ($urandom_range(0, 2) == 0);
            wr_data = $urandom;
            if (s == 6'd6) wr_data = 32'($urandom_range(0, 3));
            if (s == 6'd5) wr_data[0] = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) in_p[i] = 32'($urandom_range(0, 3));
            end
            #1;
            check("rnd_rdata", io_read_data, model_read(addr));
            check("rnd_irq", 32'(irq), 32'(m_irq));
            cyc();
            reset = 0;
            if (n % 40 == 39) sweep("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
